// File: rtl/dec_countdown_ctrl_pkg.sv
// Shared constants for the countdown controller family.
// State encodings are reused by sibling controllers.
package dec_countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/dec_countdown_ctrl_decn.sv
// N-bit decrementer shared across the codebase.
// Pure combinational: y = a - 1 (wraps at zero).
module decN #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    assign y = a - ONE;

endmodule

// File: rtl/dec_countdown_ctrl.sv
// Loadable down-counter with pause/abort control.
// Registered count, busy, tick and done outputs.
module dec_countdown_ctrl
    import dec_countdown_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] load_val,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         busy_q, busy_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic [N-1:0] count_dec;

    decN #(.N(N)) u_dec (
        .a (count_q),
        .y (count_dec)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (start) begin
                    if (load_val != '0) begin
                        count_d = load_val;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (count_q == '0) begin
                    // never decrement from zero
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_dec;
                    tick_d  = 1'b1;
                    if (count_q == ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tick  = tick_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dec_countdown_ctrl.sv
// Directed bench for dec_countdown_ctrl (N=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_dec_countdown_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] load_val;
    logic         pause;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         tick;
    logic         done;

    int n_chk;
    int n_fail;
    int n_tick;
    int n_done;

    dec_countdown_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit b,
                           input bit t, input bit d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".tick"},  32'(tick),  32'(t));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b1;
        load_val = 8'd9;
        pause    = 1'b0;
        abort    = 1'b0;
        @(negedge clk);

        // reset overrides a pending start
        cyc();
        chk_all("reset", 0, 0, 0, 0);
        rst   = 1'b0;
        start = 1'b0;
        cyc();
        chk_all("idle", 0, 0, 0, 0);

        // L=5: count 5 at cycle 1, ticks 2..6, done at 6
        start    = 1'b1;
        load_val = 8'd5;
        cyc();
        start    = 1'b0;
        load_val = 8'd200;
        chk_all("l5.load", 5, 1, 0, 0);
        for (int i = 2; i <= 6; i++) begin
            cyc();
            chk_all($sformatf("l5.c%0d", i), 6 - i, i < 6, 1, i == 6);
        end
        cyc();
        chk_all("l5.idle", 0, 0, 0, 0);

        // L=0: straight to DONE; start in DONE ignored
        start    = 1'b1;
        load_val = 8'd0;
        cyc();
        load_val = 8'd4;
        chk_all("l0.done", 0, 0, 0, 1);
        cyc();
        start = 1'b0;
        chk_all("l0.idle", 0, 0, 0, 0);
        cyc();
        chk_all("l0.idle2", 0, 0, 0, 0);

        // L=3 with a 4-cycle pause at count=2
        start    = 1'b1;
        load_val = 8'd3;
        cyc();
        start = 1'b0;
        chk_all("p.load", 3, 1, 0, 0);
        cyc();
        chk_all("p.c2", 2, 1, 1, 0);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_all($sformatf("p.hold%0d", i), 2, 1, 0, 0);
        end
        pause = 1'b0;
        cyc();
        chk_all("p.resume", 2, 1, 0, 0);
        cyc();
        chk_all("p.c1", 1, 1, 1, 0);
        cyc();
        chk_all("p.c0", 0, 0, 1, 1);
        cyc();
        chk_all("p.idle", 0, 0, 0, 0);

        // L=10, start pulses in RUN ignored, abort+pause at count=4
        start    = 1'b1;
        load_val = 8'd10;
        cyc();
        start = 1'b0;
        chk_all("a.load", 10, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            start    = k[0];
            load_val = 8'd99;
            cyc();
            chk_all($sformatf("a.k%0d", k), 10 - k, 1, 1, 0);
        end
        start = 1'b0;
        pause = 1'b1;
        abort = 1'b1;
        cyc();
        chk_all("a.abort", 0, 0, 0, 0);
        pause = 1'b0;
        abort = 1'b0;
        cyc();
        chk_all("a.idle", 0, 0, 0, 0);

        // L=255: 255 ticks, one done, no wrap
        start    = 1'b1;
        load_val = 8'd255;
        cyc();
        start = 1'b0;
        chk_all("f.load", 255, 1, 0, 0);
        n_tick = 0;
        n_done = 0;
        for (int k = 1; k <= 255; k++) begin
            cyc();
            n_tick += int'(tick);
            n_done += int'(done);
            chk($sformatf("f.count%0d", k), 32'(count), 32'(255 - k));
        end
        cyc();
        n_tick += int'(tick);
        n_done += int'(done);
        chk_all("f.idle", 0, 0, 0, 0);
        chk("f.ticks", 32'(n_tick), 32'd255);
        chk("f.dones", 32'(n_done), 32'd1);

        // reset at count=7 mid-run, then immediate restart
        start    = 1'b1;
        load_val = 8'd10;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        chk_all("r.pre", 7, 1, 1, 0);
        rst = 1'b1;
        cyc();
        chk_all("r.rst", 0, 0, 0, 0);
        rst      = 1'b0;
        start    = 1'b1;
        load_val = 8'd2;
        cyc();
        start = 1'b0;
        chk_all("r.load", 2, 1, 0, 0);
        cyc();
        chk_all("r.c1", 1, 1, 1, 0);
        cyc();
        chk_all("r.c0", 0, 0, 1, 1);
        cyc();
        chk_all("r.idle", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_countdown_ctrl.md
DEC_COUNTDOWN_CTRL -- requirements
Module: dec_countdown_ctrl

Interface
REQ-001 Parameter: N, default 8, datapath width of the count and load value.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a countdown; sampled only in IDLE.
REQ-005 load_val  input  N  initial count; captured only on an accepted start.
REQ-006 pause  input  1  while high in RUN, freezes the count.
REQ-007 abort  input  1  terminates the countdown in RUN or PAUSED without done.
REQ-008 count  output  N  current count value, registered.
REQ-009 busy  output  1  high in RUN and PAUSED only.
REQ-010 tick  output  1  one-cycle pulse for each decrement performed.
REQ-011 done  output  1  one-cycle pulse when the countdown reaches zero.

Function
REQ-012 States SHALL be IDLE, RUN, PAUSED and DONE, with all outputs registered.
REQ-013 In IDLE with start=1 and load_val=L>0, the next edge SHALL set count=L and move to RUN.
REQ-014 In IDLE with start=1 and load_val=0, the next edge SHALL move directly to DONE with count=0 and done=1.
REQ-015 In RUN with pause=0, abort=0 and count>1, each edge SHALL load count with the decremented value and set tick=1.
REQ-016 In RUN with pause=0, abort=0 and count=1, the edge SHALL set count=0, tick=1, done=1 and move to DONE.
REQ-017 In RUN with pause=1 and abort=0, the edge SHALL hold count, set tick=0 and move to PAUSED.
REQ-018 PAUSED SHALL hold count while pause=1.
REQ-019 PAUSED SHALL return to RUN on the first edge with pause=0, and that edge SHALL NOT decrement.
REQ-020 In RUN or PAUSED, abort=1 SHALL move to IDLE with count=0, tick=0 and done=0; abort SHALL take priority over pause.
REQ-021 DONE SHALL last exactly one cycle, then move unconditionally to IDLE with done=0.
REQ-022 count SHALL hold 0 in DONE and in IDLE until the next accepted start.
REQ-023 start SHALL be ignored in RUN, PAUSED and DONE; load_val SHALL be ignored except on an accepted start.
REQ-024 Latency: with start at cycle t and no pause, count=L at t+1, ticks occur at cycles t+2..t+1+L, and done=1 with count=0 at t+1+L.
REQ-025 count SHALL NEVER be decremented from 0, so no wrap-around to all-ones can occur.
REQ-026 For L=2^N-1, the countdown SHALL complete in 2^N-1 RUN cycles.
REQ-027 tick and done SHALL be 0 in every cycle not named in REQ-014 to REQ-016.

Reset
REQ-028 When rst=1 at an edge, the block SHALL set state=IDLE, count=0, busy=0, tick=0 and done=0, regardless of any other input.
REQ-029 Reset mid-countdown SHALL abandon the countdown with no done pulse.
REQ-030 The block SHALL accept start on the first edge after rst deasserts.

Structure
REQ-031 The decrement SHALL be computed by exactly one instance of the team's existing N-bit decrementer, decN, with the current count as input; there SHALL be no behavioral subtraction in this module.
REQ-032 State encodings (2-bit IDLE=0, RUN=1, PAUSED=2, DONE=3) SHALL live in a shared constants include file for reuse by sibling controllers.
REQ-033 The block SHALL contain no other sub-modules.

Verification
REQ-034 N=8, start with load_val=5 at cycle 0 -> count=5 at cycle 1, ticks at cycles 2-6, count=0 and done=1 at cycle 6, busy=0 and state IDLE at cycle 7.
REQ-035 start with load_val=0 -> done=1 at the next cycle, no tick, busy never 1.
REQ-036 load_val=3, pause held for 4 cycles after count=2 -> count stays 2 with no ticks; one non-decrementing resume cycle; done 4+1 cycles later than without pause.
REQ-037 load_val=10, abort at count=4 with pause=1 -> IDLE next cycle with count=0, no done; start pulses during RUN are ignored.
REQ-038 load_val=255 (N=8) -> exactly 255 ticks, done once, count never 255 after leaving 255 (no wrap).
REQ-039 rst pulse at count=7 mid-run -> all outputs 0 next cycle; a new start one cycle after rst is accepted.
